// File: rtl/ca_pkg.sv
// Shared types and constants for the 1-D elementary cellular-automaton engine.
package ca_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt
  } ca_state_e;

  localparam int unsigned BOUNDARY_WRAP = 0;
  localparam int unsigned BOUNDARY_ZERO = 1;

endpackage

// File: rtl/ca_next_line.sv
// Combinational rule application: every cell looks up rule[{left, self, right}].
module ca_next_line
  import ca_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned BOUNDARY = BOUNDARY_WRAP
) (
  input  logic [WIDTH-1:0] line,
  input  logic [7:0]       rule,
  output logic [WIDTH-1:0] nxt
);

  localparam bit ZeroEdge = (BOUNDARY == BOUNDARY_ZERO);

  // Edge neighbours either wrap around the ring or read as dead cells.
  logic [WIDTH+1:0] ext;
  assign ext = {ZeroEdge ? 1'b0 : line[0], line, ZeroEdge ? 1'b0 : line[WIDTH-1]};

  // ext[i] is the left neighbour (data[i-1]), ext[i+2] the right one (data[i+1]).
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    assign nxt[i] = rule[{ext[i], ext[i+1], ext[i+2]}];
  end

endmodule

// File: rtl/ca_engine.sv
// Elementary CA engine: holds one line, advances it by a loadable rule on a prescaled tick
// (free run) or a single-step pulse, counts generations and halts at a fixed point.
module ca_engine
  import ca_pkg::*;
#(
  parameter int unsigned       WIDTH         = 8,
  parameter int unsigned       TICK_DIV      = 2 ** 23,
  parameter int unsigned       GEN_W         = 16,
  parameter logic [7:0]        DEFAULT_RULE  = 8'd129,
  parameter logic [WIDTH-1:0]  DEFAULT_SEED  = {{(WIDTH - 1) {1'b0}}, 1'b1},
  parameter int unsigned       BOUNDARY      = BOUNDARY_WRAP,
  parameter bit                STOP_ON_STILL = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [7:0]       cfg_rule,
  input  logic [WIDTH-1:0] cfg_seed,
  input  logic             run,
  input  logic             step,
  output logic [WIDTH-1:0] data,
  output logic [GEN_W-1:0] gen,
  output logic             still,
  output logic             halted
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TickLast = CNT_W'(TICK_DIV - 1);

  ca_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [7:0]       rule_q, rule_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             still_q, still_d;

  logic [WIDTH-1:0] nxt;
  logic             tick;
  logic             advance;
  logic             load;

  ca_next_line #(
    .WIDTH    (WIDTH),
    .BOUNDARY (BOUNDARY)
  ) u_next_line (
    .line (data_q),
    .rule (rule_q),
    .nxt  (nxt)
  );

  assign tick = (cnt_q == TickLast);

  // FSM next state, tick prescaler and load/advance decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;  // counter only runs in RUN, so it restarts on every entry
    advance = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          load = 1'b1;
        end else if (step) begin
          advance = 1'b1;
        end else if (run) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!run) begin
          state_d = StIdle;
        end else begin
          cnt_d = tick ? '0 : cnt_q + 1'b1;
          if (tick) begin
            advance = 1'b1;
            if (STOP_ON_STILL && (nxt == data_q)) begin
              state_d = StHalt;
            end
          end
        end
      end
      StHalt: begin
        if (cfg_valid) begin
          load    = 1'b1;
          state_d = StIdle;
        end else if (!run) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line, rule, generation and still-flag updates selected by the FSM.
  always_comb begin
    data_d  = data_q;
    rule_d  = rule_q;
    gen_d   = gen_q;
    still_d = still_q;
    if (load) begin
      data_d  = cfg_seed;
      rule_d  = cfg_rule;
      gen_d   = '0;
      still_d = 1'b0;
    end else if (advance) begin
      data_d  = nxt;
      gen_d   = (gen_q == '1) ? gen_q : gen_q + 1'b1;
      still_d = (nxt == data_q);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= DEFAULT_SEED;
      rule_q  <= DEFAULT_RULE;
      gen_q   <= '0;
      still_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rule_q  <= rule_d;
      gen_q   <= gen_d;
      still_q <= still_d;
    end
  end

  assign cfg_ready = (state_q != StRun);
  assign halted    = (state_q == StHalt);
  assign data      = data_q;
  assign gen       = gen_q;
  assign still     = still_q;

endmodule

// File: tb/tb_ca_engine.sv
// Self-checking bench for ca_engine: directed scenarios plus a randomized run against a
// behavioural model, across three parameterisations sharing one stimulus.
module tb_ca_engine;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_rule = 8'd0;
  logic [7:0] cfg_seed = 8'd0;
  logic       run = 1'b0;
  logic       step = 1'b0;

  // dut0: wrap, every-cycle tick; dut1: zero boundary; dut2: 2-bit gen, tick every 3 cycles.
  logic [7:0]  d0, d1, d2;
  logic [15:0] g0, g1;
  logic [1:0]  g2;
  logic        s0, s1, s2, h0, h1, h2, r0, r1, r2;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ca_engine #(.WIDTH(8), .TICK_DIV(1), .GEN_W(16), .BOUNDARY(0)) dut0 (
    .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(r0), .cfg_rule(cfg_rule),
    .cfg_seed(cfg_seed), .run(run), .step(step), .data(d0), .gen(g0), .still(s0), .halted(h0)
  );

  ca_engine #(.WIDTH(8), .TICK_DIV(1), .GEN_W(16), .BOUNDARY(1)) dut1 (
    .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(r1), .cfg_rule(cfg_rule),
    .cfg_seed(cfg_seed), .run(run), .step(step), .data(d1), .gen(g1), .still(s1), .halted(h1)
  );

  ca_engine #(.WIDTH(8), .TICK_DIV(3), .GEN_W(2), .BOUNDARY(0)) dut2 (
    .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(r2), .cfg_rule(cfg_rule),
    .cfg_seed(cfg_seed), .run(run), .step(step), .data(d2), .gen(g2), .still(s2), .halted(h2)
  );

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 free-running, 2 halted at a fixed point
  typedef struct {
    logic [7:0]  line;
    logic [7:0]  rule;
    int unsigned gen;
    bit          still;
    int          mode;
    int unsigned ticks;  // cycles spent in free run since entering it
  } model_t;

  model_t m0, m1, m2;

  function automatic logic [7:0] life(input logic [7:0] cur, input logic [7:0] rule,
                                      input bit zero_edge);
    logic [7:0] res;
    for (int i = 0; i < 8; i++) begin
      int  left_i  = (i + 7) % 8;
      int  right_i = (i + 1) % 8;
      bit  l = (zero_edge && i == 0) ? 1'b0 : cur[left_i];
      bit  r = (zero_edge && i == 7) ? 1'b0 : cur[right_i];
      int  idx = 4 * int'(l) + 2 * int'(cur[i]) + int'(r);
      res[i] = rule[idx];
    end
    return res;
  endfunction

  function automatic model_t mstep(input model_t m, input bit zero_edge, input int unsigned div,
                                   input int unsigned gmax);
    model_t     r = m;
    logic [7:0] n = life(m.line, m.rule, zero_edge);
    bit         adv = 1'b0;
    bit         ld = 1'b0;
    if (!rstn) begin
      r.line = 8'h01; r.rule = 8'd129; r.gen = 0; r.still = 1'b0; r.mode = 0; r.ticks = 0;
      return r;
    end
    if (m.mode == 0) begin
      if (cfg_valid) ld = 1'b1;
      else if (step) adv = 1'b1;
      else if (run) begin r.mode = 1; r.ticks = 0; end
    end else if (m.mode == 1) begin
      if (!run) r.mode = 0;
      else begin
        r.ticks = m.ticks + 1;
        if (r.ticks % div == 0) begin
          adv = 1'b1;
          if (n == m.line) r.mode = 2;
        end
      end
    end else begin
      if (cfg_valid) begin ld = 1'b1; r.mode = 0; end
      else if (!run) r.mode = 0;
    end
    if (ld) begin
      r.line = cfg_seed; r.rule = cfg_rule; r.gen = 0; r.still = 1'b0;
    end else if (adv) begin
      r.line = n; r.gen = (m.gen >= gmax) ? gmax : m.gen + 1; r.still = (n == m.line);
    end
    return r;
  endfunction

  // One clock: update models from the inputs about to be sampled, then sample after the edge.
  task automatic cycle();
    m0 = mstep(m0, 1'b0, 1, 65535);
    m1 = mstep(m1, 1'b1, 1, 65535);
    m2 = mstep(m2, 1'b0, 3, 3);
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] rule, input logic [7:0] seed);
    cfg_valid = 1'b1; cfg_rule = rule; cfg_seed = seed;
    cycle();
    cfg_valid = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0;
    cycle();
    n_checks++;
    if ({d0, g0, s0, h0, r0} !== {8'h01, 16'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: data=%h gen=%0d still=%b halted=%b ready=%b, want 01 0 0 0 1",
               d0, g0, s0, h0, r0);
    end
    n_checks++;
    if ({d2, g2, h2, r2} !== {8'h01, 2'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_dut2: data=%h gen=%0d halted=%b ready=%b, want 01 0 0 1",
               d2, g2, h2, r2);
    end
    rstn = 1'b1;
  endtask

  task automatic test_rule90();
    logic [7:0] want [3] = '{8'h14, 8'h22, 8'h55};
    load(8'd90, 8'h08);
    step = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_checks++;
      if (d0 !== want[k] || g0 !== 16'(k + 1)) begin
        n_fail++;
        $display("FAIL rule90_step%0d: data=%h gen=%0d, want %h %0d", k, d0, g0, want[k], k + 1);
      end
      n_checks++;
      if (d1 !== want[k]) begin
        n_fail++;
        $display("FAIL rule90_zero_step%0d: data=%h, want %h", k, d1, want[k]);
      end
    end
    step = 1'b0;
  endtask

  task automatic test_boundary();
    load(8'd90, 8'h80);
    step = 1'b1;
    cycle();
    step = 1'b0;
    n_checks++;
    if (d0 !== 8'h41) begin
      n_fail++;
      $display("FAIL boundary_wrap: data=%h, want 41", d0);
    end
    n_checks++;
    if (d1 !== 8'h40) begin
      n_fail++;
      $display("FAIL boundary_zero: data=%h, want 40", d1);
    end
  endtask

  task automatic test_fixed_point();
    load(8'd204, 8'hA5);
    run = 1'b1;
    cycle();
    n_checks++;
    if (h0 !== 1'b0 || d0 !== 8'hA5 || g0 !== 16'd0 || r0 !== 1'b0) begin
      n_fail++;
      $display("FAIL fixed_enter_run: halted=%b data=%h gen=%0d ready=%b, want 0 a5 0 0",
               h0, d0, g0, r0);
    end
    for (int k = 0; k < 4; k++) begin
      cycle();
      n_checks++;
      if ({d0, g0, s0, h0} !== {8'hA5, 16'd1, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL fixed_halt%0d: data=%h gen=%0d still=%b halted=%b, want a5 1 1 1",
                 k, d0, g0, s0, h0);
      end
    end
    run = 1'b0;
    cycle();
    n_checks++;
    if (h0 !== 1'b0 || r0 !== 1'b1) begin
      n_fail++;
      $display("FAIL fixed_release: halted=%b ready=%b, want 0 1", h0, r0);
    end
  endtask

  task automatic test_handshake();
    load(8'd90, 8'h08);
    run = 1'b1;
    cycle();
    cfg_valid = 1'b1; cfg_rule = 8'd0; cfg_seed = 8'hFF;
    n_checks++;
    if (r0 !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_ready_in_run: ready=%b, want 0", r0);
    end
    cycle();
    n_checks++;
    if (d0 !== 8'h14 || g0 !== 16'd1) begin
      n_fail++;
      $display("FAIL hs_ignored: data=%h gen=%0d, want 14 1", d0, g0);
    end
    run = 1'b0;
    cycle();
    n_checks++;
    if (d0 !== 8'h14 || g0 !== 16'd1 || r0 !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_stop: data=%h gen=%0d ready=%b, want 14 1 1", d0, g0, r0);
    end
    cycle();
    cfg_valid = 1'b0;
    n_checks++;
    if (d0 !== 8'hFF || g0 !== 16'd0 || s0 !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_accept: data=%h gen=%0d still=%b, want ff 0 0", d0, g0, s0);
    end
    step = 1'b1;
    cycle();
    step = 1'b0;
    n_checks++;
    if (d0 !== 8'h00 || g0 !== 16'd1) begin
      n_fail++;
      $display("FAIL hs_new_rule: data=%h gen=%0d, want 00 1", d0, g0);
    end
  endtask

  task automatic test_saturation_reset();
    load(8'd51, 8'h0F);  // rule 51 complements every cell, so never still
    run = 1'b1;
    cycle();
    for (int k = 0; k < 15; k++) cycle();
    n_checks++;
    if (g2 !== 2'd3 || d2 !== 8'hF0 || h2 !== 1'b0 || s2 !== 1'b0) begin
      n_fail++;
      $display("FAIL saturate: gen=%0d data=%h halted=%b still=%b, want 3 f0 0 0",
               g2, d2, h2, s2);
    end
    n_checks++;
    if (g0 !== 16'd15) begin
      n_fail++;
      $display("FAIL free_run_count: gen=%0d, want 15", g0);
    end
    rstn = 1'b0;
    cycle();
    n_checks++;
    if ({d2, g2, s2, h2, r2} !== {8'h01, 2'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_run: data=%h gen=%0d still=%b halted=%b ready=%b, want 01 0 0 0 1",
               d2, g2, s2, h2, r2);
    end
    n_checks++;
    if ({d0, g0, r0} !== {8'h01, 16'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_run_dut0: data=%h gen=%0d ready=%b, want 01 0 1", d0, g0, r0);
    end
    rstn = 1'b1;
    run = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      rstn = ($urandom_range(0, 199) != 0);
      cfg_valid = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 4))
        0: cfg_rule = 8'd204;
        1: cfg_rule = 8'd90;
        2: cfg_rule = 8'd0;
        3: cfg_rule = 8'd30;
        default: cfg_rule = 8'($urandom);
      endcase
      cfg_seed = 8'($urandom);
      if ($urandom_range(0, 9) == 0) run = ~run;
      step = ($urandom_range(0, 4) == 0);
      cycle();
      n_checks++;
      if ({d0, g0, s0, h0, r0} !== {m0.line, 16'(m0.gen), m0.still, m0.mode == 2, m0.mode != 1})
      begin
        n_fail++;
        $display("FAIL random_dut0 cyc%0d: data=%h gen=%0d still=%b halted=%b ready=%b, want %h %0d %b %b %b",
                 c, d0, g0, s0, h0, r0, m0.line, m0.gen, m0.still, m0.mode == 2, m0.mode != 1);
      end
      n_checks++;
      if ({d1, g1, s1, h1, r1} !== {m1.line, 16'(m1.gen), m1.still, m1.mode == 2, m1.mode != 1})
      begin
        n_fail++;
        $display("FAIL random_dut1 cyc%0d: data=%h gen=%0d still=%b halted=%b ready=%b, want %h %0d %b %b %b",
                 c, d1, g1, s1, h1, r1, m1.line, m1.gen, m1.still, m1.mode == 2, m1.mode != 1);
      end
      n_checks++;
      if ({d2, g2, s2, h2, r2} !== {m2.line, 2'(m2.gen), m2.still, m2.mode == 2, m2.mode != 1})
      begin
        n_fail++;
        $display("FAIL random_dut2 cyc%0d: data=%h gen=%0d still=%b halted=%b ready=%b, want %h %0d %b %b %b",
                 c, d2, g2, s2, h2, r2, m2.line, m2.gen, m2.still, m2.mode == 2, m2.mode != 1);
      end
    end
    rstn = 1'b1; cfg_valid = 1'b0; run = 1'b0; step = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rule90();
    test_boundary();
    test_fixed_point();
    test_handshake();
    test_saturation_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
